// File: rtl/ccff_chain_loader_pkg.sv
// Shared types for the configuration-chain loader: controller states and pass modes.
// Imported by the top-level controller and the bench.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } ccff_state_e;

    typedef enum logic {
        MODE_LOAD   = 1'b0,
        MODE_VERIFY = 1'b1
    } ccff_mode_e;

    // Width of a counter that indexes 0..n-1 (never narrower than one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_word_serializer.sv
// Parallel-to-serial word register feeding the configuration chain, LSB first.
// Tracks the bit position inside the current word and flags the last bit.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] load_data,
    output logic              cur_bit,
    output logic              next_bit,
    output logic              last_bit
);

    localparam int BW = idx_width(WORD_W);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bidx_q,  bidx_d;

    always_comb begin
        shreg_d = shreg_q;
        bidx_d  = bidx_q;
        if (load) begin
            shreg_d = load_data;
            bidx_d  = '0;
        end else if (shift) begin
            shreg_d = shreg_q >> 1;
            bidx_d  = bidx_q + 1'b1;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shreg_q <= '0;
            bidx_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            bidx_q  <= bidx_d;
        end
    end

    assign cur_bit  = shreg_q[0];
    // Bit that will sit at the serial position after this cycle's load/shift.
    assign next_bit = shreg_d[0];
    assign last_bit = (bidx_q == BW'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain controller: serialises host words onto the ccff chain and,
// in verify mode, compares the returning chain tail against the re-sent bitstream.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              ccff_head,
    output logic              chain_shift,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_idx
);

    ccff_state_e      state_q,   state_d;
    ccff_mode_e       mode_q,    mode_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic             head_q,    head_d;
    logic             shift_q,   shift_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;

    logic ser_load;
    logic ser_shift;
    logic ser_cur_bit;
    logic ser_next_bit;
    logic ser_last_bit;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .load      (ser_load),
        .shift     (ser_shift),
        .load_data (wr_data),
        .cur_bit   (ser_cur_bit),
        .next_bit  (ser_next_bit),
        .last_bit  (ser_last_bit)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d    = verify ? MODE_VERIFY : MODE_LOAD;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (wr_valid) begin
                    ser_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_shift = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // Tail now holds the same-index bit from the previous pass.
                if (mode_q == MODE_VERIFY && ccff_tail != ser_cur_bit && !err_q) begin
                    err_d     = 1'b1;
                    err_idx_d = cnt_q;
                end
                if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = ST_FINISH;
                end else if (ser_last_bit) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        head_d  = (state_d == ST_SHIFT) ? ser_next_bit : 1'b0;
        shift_d = (state_d == ST_SHIFT);
        done_d  = (state_d == ST_FINISH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_LOAD;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            head_q    <= 1'b0;
            shift_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            head_q    <= head_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_ready    = (state_q == ST_FETCH);
    assign ccff_head   = head_q;
    assign chain_shift = shift_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 20-flop behavioural chain on the tail.
// Prints one line per pass and a final summary.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam logic [19:0] EXP_SEQ = 20'hF3CA5;

    logic              clk = 1'b0;
    logic              pReset = 1'b1;
    logic              start = 1'b0;
    logic              verify = 1'b0;
    logic [WORD_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic              ccff_head;
    logic              chain_shift;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  err_idx;

    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] snap;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] seq;
    int          nbits;
    int          cyc;
    int          widx;
    logic        err_fetch;
    logic        got_done;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .prog_clk    (clk),
        .pReset      (pReset),
        .start       (start),
        .verify      (verify),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .ccff_head   (ccff_head),
        .chain_shift (chain_shift),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_idx     (err_idx)
    );

    always #5 clk = ~clk;

    // Behavioural configuration chain: chain[0] is the head flop, chain[19] the tail.
    always @(posedge clk) begin
        if (chain_shift) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({tag, "_head"},     32'(ccff_head), 32'd0);
        check({tag, "_shift"},    32'(chain_shift), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_done"},     32'(done), 32'd0);
        check({tag, "_err"},      32'(err), 32'd0);
        check({tag, "_err_idx"},  32'(err_idx), 32'd0);
    endtask

    // Runs one pass. Cycle 1 is the cycle start is asserted; cyc ends as the cycle done is high.
    task automatic run_pass(input string name, input logic vmode,
                            input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int stall_n, input int poke_bit, input int rst_bit);
        logic [7:0] words [3];
        int   stall_cnt;
        logic acc;
        words[0] = w0; words[1] = w1; words[2] = w2;
        seq = '0; nbits = 0; widx = 0; stall_cnt = 0; err_fetch = 1'bx; got_done = 1'b0;
        verify = vmode;
        start  = 1'b1;
        wr_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (cyc < 200) begin
            if (cyc == 2) err_fetch = err;
            if (chain_shift) begin
                if (nbits < 20) seq[nbits] = ccff_head;
                nbits++;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (rst_bit >= 0 && nbits == rst_bit && chain_shift) begin
                check("rst_pre_busy", 32'(busy), 32'd1);
                check("rst_pre_head", 32'(ccff_head), 32'd1);
                pReset = 1'b1;
                #1;
                check_idle_outputs("rst_async");
                @(posedge clk); #1;
                check("rst_hold_busy", 32'(busy), 32'd0);
                pReset = 1'b0;
                wr_valid = 1'b0;
                $display("pass %s: reset applied after %0d shifts", name, nbits);
                return;
            end
            start = (poke_bit >= 0 && nbits == poke_bit && chain_shift);
            wr_valid = 1'b0;
            if (widx < 3) begin
                if (widx == 1 && wr_ready && stall_cnt < stall_n) begin
                    stall_cnt++;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = words[widx];
                end
            end
            acc = wr_valid && wr_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) widx++;
        end
        wr_valid = 1'b0;
        check({name, "_done_seen"}, 32'(got_done), 32'd1);
        // A start coincident with done must not launch a new pass.
        start  = 1'b1;
        verify = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_start_at_done"}, 32'(busy), 32'd0);
        $display("pass %s: cycles=%0d shifts=%0d seq=%05h words=%0d err=%0b err_idx=%0d",
                 name, cyc, nbits, seq, widx, err, err_idx);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        pReset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Plain load pass.
        run_pass("load", 1'b0, 8'hA5, 8'h3C, 8'h0F, 0, -1, -1);
        check("load_cycles", 32'(cyc), 32'd25);
        check("load_shifts", 32'(nbits), 32'd20);
        check("load_seq", 32'(seq), 32'(EXP_SEQ));
        check("load_words", 32'(widx), 32'd3);
        check("load_err", 32'(err), 32'd0);
        check("load_tail", 32'(chain[19]), 32'd1);
        check("load_chain_head", 32'(chain[0]), 32'd1);

        // Verify with identical data: no error, chain content preserved.
        snap = chain;
        run_pass("verify_ok", 1'b1, 8'hA5, 8'h3C, 8'h0F, 0, -1, -1);
        check("vok_err", 32'(err), 32'd0);
        check("vok_chain", 32'(chain), 32'(snap));
        check("vok_cycles", 32'(cyc), 32'd25);

        // Bit 8 differs (0x3D vs 0x3C).
        run_pass("verify_bad", 1'b1, 8'hA5, 8'h3D, 8'h0F, 0, -1, -1);
        check("vbad_err", 32'(err), 32'd1);
        check("vbad_idx", 32'(err_idx), 32'd8);

        // Mismatches at bits 8 and 16; err cleared by start, index stays at the first.
        run_pass("verify_two", 1'b1, 8'hA5, 8'h3C, 8'h0E, 0, -1, -1);
        check("vtwo_err_cleared", 32'(err_fetch), 32'd0);
        check("vtwo_err", 32'(err), 32'd1);
        check("vtwo_idx", 32'(err_idx), 32'd8);

        // Host stalls 5 cycles before the second word.
        run_pass("stall", 1'b0, 8'hA5, 8'h3C, 8'h0F, 5, -1, -1);
        check("stall_cycles", 32'(cyc), 32'd30);
        check("stall_seq", 32'(seq), 32'(EXP_SEQ));
        check("stall_shifts", 32'(nbits), 32'd20);

        // start pulse while shifting must be ignored.
        run_pass("poke", 1'b0, 8'hA5, 8'h3C, 8'h0F, 0, 5, -1);
        check("poke_cycles", 32'(cyc), 32'd25);
        check("poke_seq", 32'(seq), 32'(EXP_SEQ));
        check("poke_err", 32'(err), 32'd0);

        // Reset mid-pass, then a full reload.
        run_pass("reset_mid", 1'b0, 8'hA5, 8'h3C, 8'h0F, 0, -1, 12);
        @(posedge clk); #1;
        run_pass("reload", 1'b0, 8'hA5, 8'h3C, 8'h0F, 0, -1, -1);
        check("reload_cycles", 32'(cyc), 32'd25);
        check("reload_seq", 32'(seq), 32'(EXP_SEQ));

        run_pass("verify_final", 1'b1, 8'hA5, 8'h3C, 8'h0F, 0, -1, -1);
        check("vfin_err", 32'(err), 32'd0);
        check("vfin_cycles", 32'(cyc), 32'd25);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
